// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA encrypt/decrypt round-trip sequencer.
package rsa_pkg;

  localparam int DEF_WIDTH   = 128;
  localparam int DEF_TIMEOUT = 2 ** 20;

  typedef enum logic [3:0] {
    IDLE,
    INV_PULSE,
    INV_GUARD,
    INV_WAIT,
    EXP_PULSE,
    EXP_GUARD,
    EXP_WAIT,
    CAPTURE,
    DONE
  } state_t;

endpackage

// File: rtl/rsa_roundtrip_seq_if.sv
// Host request/result signals plus the control-engine operand and flag bus.
interface rsa_roundtrip_seq_if import rsa_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);
  logic                 start;
  logic [WIDTH-1:0]     p_in;
  logic [WIDTH-1:0]     q_in;
  logic [2*WIDTH-1:0]   msg_in;
  logic [WIDTH-1:0]     ctl_p;
  logic [WIDTH-1:0]     ctl_q;
  logic                 ctl_reset_inverter;
  logic                 ctl_reset_mod_exp;
  logic                 ctl_encrypt_decrypt;
  logic [2*WIDTH-1:0]   ctl_msg;
  logic                 ctl_inverter_finish;
  logic                 ctl_mod_exp_finish;
  logic [2*WIDTH-1:0]   ctl_msg_out;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic                 timeout;
  logic [2*WIDTH-1:0]   cipher;
  logic [2*WIDTH-1:0]   plain_out;

  modport slave (
    input  start, p_in, q_in, msg_in,
    input  ctl_inverter_finish, ctl_mod_exp_finish, ctl_msg_out,
    output ctl_p, ctl_q, ctl_reset_inverter, ctl_reset_mod_exp,
    output ctl_encrypt_decrypt, ctl_msg,
    output busy, done, pass, timeout, cipher, plain_out
  );

  modport master (
    output start, p_in, q_in, msg_in,
    output ctl_inverter_finish, ctl_mod_exp_finish, ctl_msg_out,
    input  ctl_p, ctl_q, ctl_reset_inverter, ctl_reset_mod_exp,
    input  ctl_encrypt_decrypt, ctl_msg,
    input  busy, done, pass, timeout, cipher, plain_out
  );
endinterface

// File: rtl/rsa_wait_timer.sv
// Down-counting wait budget: load the budget, count down while enabled,
// expired is high once the count has reached zero.
module rsa_wait_timer #(
  parameter int CW = 21
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          ld_i,
  input  logic [CW-1:0] ld_val_i,
  input  logic          en_i,
  output logic          expired_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (ld_i)
      cnt_d = ld_val_i;
    else if (en_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/rsa_roundtrip_seq.sv
// Sequences an external RSA engine through encrypt then decrypt of one message
// and reports whether the recovered plaintext matches, with a per-wait timeout.
module rsa_roundtrip_seq import rsa_pkg::*; #(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic               clk,
  input logic               reset,
  rsa_roundtrip_seq_if.slave bus
);

  localparam int MW = 2 * WIDTH;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic             phase_q, phase_d;
  logic             mode_q, mode_d;
  logic             pass_q, pass_d;
  logic             tmo_q, tmo_d;
  logic [WIDTH-1:0] p_q, p_d, q_q, q_d;
  logic [MW-1:0]    msg_q, msg_d;
  logic [MW-1:0]    ctl_msg_q, ctl_msg_d;
  logic [MW-1:0]    cipher_q, cipher_d;
  logic [MW-1:0]    plain_q, plain_d;
  logic             tmr_clr, tmr_ld, tmr_en, tmr_exp;

  rsa_wait_timer #(.CW(CW)) u_timer (
    .clk       (clk),
    .rst       (reset),
    .clr_i     (tmr_clr),
    .ld_i      (tmr_ld),
    .ld_val_i  (CW'(TIMEOUT - 1)),
    .en_i      (tmr_en),
    .expired_o (tmr_exp)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    mode_d    = mode_q;
    pass_d    = pass_q;
    tmo_d     = tmo_q;
    p_d       = p_q;
    q_d       = q_q;
    msg_d     = msg_q;
    ctl_msg_d = ctl_msg_q;
    cipher_d  = cipher_q;
    plain_d   = plain_q;
    tmr_clr   = 1'b0;
    tmr_ld    = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_clr = 1'b1;
        if (bus.start) begin
          p_d       = bus.p_in;
          q_d       = bus.q_in;
          msg_d     = bus.msg_in;
          ctl_msg_d = bus.msg_in;
          mode_d    = 1'b0;
          phase_d   = 1'b0;
          pass_d    = 1'b0;
          tmo_d     = 1'b0;
          cipher_d  = '0;
          plain_d   = '0;
          state_d   = INV_PULSE;
        end
      end
      INV_PULSE: state_d = INV_GUARD;
      // Guard cycles load the budget and never look at the finish flags.
      INV_GUARD: begin
        tmr_ld  = 1'b1;
        state_d = INV_WAIT;
      end
      INV_WAIT: begin
        tmr_en = 1'b1;
        if (bus.ctl_inverter_finish) begin
          state_d = EXP_PULSE;
        end else if (tmr_exp) begin
          tmo_d   = 1'b1;
          pass_d  = 1'b0;
          state_d = DONE;
        end
      end
      EXP_PULSE: state_d = EXP_GUARD;
      EXP_GUARD: begin
        tmr_ld  = 1'b1;
        state_d = EXP_WAIT;
      end
      EXP_WAIT: begin
        tmr_en = 1'b1;
        if (bus.ctl_mod_exp_finish) begin
          state_d = CAPTURE;
        end else if (tmr_exp) begin
          tmo_d   = 1'b1;
          pass_d  = 1'b0;
          state_d = DONE;
        end
      end
      CAPTURE: begin
        if (!phase_q) begin
          cipher_d  = bus.ctl_msg_out;
          ctl_msg_d = bus.ctl_msg_out;
          mode_d    = 1'b1;
          phase_d   = 1'b1;
          state_d   = INV_PULSE;
        end else begin
          plain_d = bus.ctl_msg_out;
          pass_d  = (bus.ctl_msg_out == msg_q);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      phase_q   <= 1'b0;
      mode_q    <= 1'b0;
      pass_q    <= 1'b0;
      tmo_q     <= 1'b0;
      p_q       <= '0;
      q_q       <= '0;
      msg_q     <= '0;
      ctl_msg_q <= '0;
      cipher_q  <= '0;
      plain_q   <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      mode_q    <= mode_d;
      pass_q    <= pass_d;
      tmo_q     <= tmo_d;
      p_q       <= p_d;
      q_q       <= q_d;
      msg_q     <= msg_d;
      ctl_msg_q <= ctl_msg_d;
      cipher_q  <= cipher_d;
      plain_q   <= plain_d;
    end
  end

  assign bus.ctl_p               = p_q;
  assign bus.ctl_q               = q_q;
  assign bus.ctl_msg             = ctl_msg_q;
  assign bus.ctl_encrypt_decrypt = mode_q;
  assign bus.ctl_reset_inverter  = (state_q == INV_PULSE);
  assign bus.ctl_reset_mod_exp   = (state_q == EXP_PULSE);
  assign bus.busy                = (state_q != IDLE);
  assign bus.done                = (state_q == DONE);
  assign bus.pass                = pass_q;
  assign bus.timeout             = tmo_q;
  assign bus.cipher              = cipher_q;
  assign bus.plain_out           = plain_q;

endmodule

// File: doc/rsa_roundtrip_seq.md
RSA_ROUNDTRIP_SEQ -- requirements
Module: rsa_roundtrip_seq

Interface
REQ-001 Parameter WIDTH, default 128: bit width of primes p and q; message width is 2*WIDTH.
REQ-002 Parameter TIMEOUT, default 2**20: maximum cycles to wait for any single finish flag.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request; sampled only in IDLE.
REQ-006 p_in, q_in  input  WIDTH each  primes, captured on an accepted start.
REQ-007 msg_in  input  2*WIDTH  plaintext, captured on an accepted start.
REQ-008 ctl_p, ctl_q  output  WIDTH each  prime operands driven to the control engine.
REQ-009 ctl_reset_inverter, ctl_reset_mod_exp  output  1 each  start pulses to the engine.
REQ-010 ctl_encrypt_decrypt  output  1  engine mode: 0 = encrypt, 1 = decrypt.
REQ-011 ctl_msg  output  2*WIDTH  engine message operand.
REQ-012 ctl_inverter_finish, ctl_mod_exp_finish  input  1 each  engine completion flags.
REQ-013 ctl_msg_out  input  2*WIDTH  engine result.
REQ-014 busy  output  1  high from accepted start until done.
REQ-015 done  output  1  one-cycle pulse when a round trip ends (pass, fail or timeout).
REQ-016 pass  output  1  valid with done and held until the next start; 1 = decrypted result equals msg_in.
REQ-017 timeout  output  1  valid with done and held; 1 = a finish flag was not seen within TIMEOUT cycles.
REQ-018 cipher, plain_out  output  2*WIDTH each  captured ciphertext and recovered plaintext.

Function
REQ-019 The FSM states SHALL be IDLE, INV_PULSE, INV_GUARD, INV_WAIT, EXP_PULSE, EXP_GUARD, EXP_WAIT, CAPTURE, DONE.
REQ-020 A phase bit SHALL select encrypt (phase 0: ctl_msg = captured msg, mode 0) or decrypt (phase 1: ctl_msg = cipher, mode 1).
REQ-021 IDLE + start SHALL capture p_in, q_in and msg_in, clear phase, pass, timeout, cipher and plain_out, and move to INV_PULSE.
REQ-022 INV_PULSE SHALL assert ctl_reset_inverter for exactly one cycle, then move to INV_GUARD.
REQ-023 The GUARD states SHALL last exactly one cycle and SHALL ignore finish flags, so a stale flag from the previous run is not taken.
REQ-024 INV_WAIT SHALL move to EXP_PULSE on the first cycle ctl_inverter_finish = 1.
REQ-025 EXP_PULSE SHALL assert ctl_reset_mod_exp for exactly one cycle, then go to EXP_GUARD, then EXP_WAIT.
REQ-026 EXP_WAIT SHALL move to CAPTURE on the first cycle ctl_mod_exp_finish = 1.
REQ-027 CAPTURE, phase 0: cipher <= ctl_msg_out, set phase 1, go to INV_PULSE.
REQ-028 CAPTURE, phase 1: plain_out <= ctl_msg_out, pass <= (ctl_msg_out == captured msg), go to DONE.
REQ-029 DONE SHALL pulse done for one cycle and return to IDLE; busy SHALL be low in IDLE only.
REQ-030 The wait counter SHALL clear on entry to each WAIT state; reaching TIMEOUT SHALL set timeout = 1 and pass = 0 and go to DONE.
REQ-031 ctl_p, ctl_q, ctl_msg and ctl_encrypt_decrypt SHALL be registered and stable from each PULSE state until the following CAPTURE.
REQ-032 start while busy SHALL be ignored, with no effect on state or captured operands.
REQ-033 Each round trip takes exactly 2*(6 + Ti + Te) cycles from start to done, where Ti and Te are the finish-wait cycles (start accept, PULSE, GUARD, Ti, PULSE, GUARD, Te, CAPTURE per phase, and DONE counted within).

Reset
REQ-034 Asserting reset SHALL force IDLE at once, whatever the state; the engine is not drained.
REQ-035 In reset, all outputs SHALL be 0: the two ctl_reset strobes, ctl_p, ctl_q, ctl_msg, ctl_encrypt_decrypt, busy, done, pass, timeout, cipher and plain_out.
REQ-036 After reset is released, the first start SHALL behave the same as after power-up.

Structure
REQ-037 A shared package rsa_pkg SHALL hold the FSM state enum, the default WIDTH and the default TIMEOUT.
REQ-038 One sub-module SHALL be used: rsa_wait_timer, a loadable cycle counter with a clear input and an expired output.
REQ-039 The engine SHALL be external, with no instance inside this block.

Verification
REQ-040 WIDTH=128, p=113680897410347, q=7999808077935876437321, msg=256'h00262d806a3e18f03ab37b2857e7e100 -> done with pass=1, timeout=0, plain_out=msg, cipher!=msg.
REQ-041 p=8475698667747010771, q=11297384090418420749, msg=256'he2590000 -> pass=1; ctl_encrypt_decrypt is 0 in phase 0 and 1 in phase 1; four one-cycle strobes in total.
REQ-042 Engine model holds ctl_mod_exp_finish low -> after TIMEOUT (set to 64) wait cycles: done, timeout=1, pass=0, busy low.
REQ-043 Engine finish flags stuck high from the previous run -> GUARD cycles ignore them and the strobe order is unchanged.
REQ-044 reset asserted during EXP_WAIT of phase 1 -> all outputs 0 at once; next start with p=9005980475000482739, q=2627021771666544701, msg=256'h7481a -> pass=1.
REQ-045 Corrupting engine model (ctl_msg_out XOR 1 in phase 1) -> done, pass=0, timeout=0.
